// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: shares one synchronous FIFO write port among NREQ producers,
// granting bounded bursts and acknowledging each word as it is written.
module fifo_wr_arbiter #(
    parameter int unsigned BITWIDTH  = 5,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*BITWIDTH-1:0]   data,
    output logic [NREQ-1:0]            ack,
    input  logic                       fifoFull,
    output logic                       fifoWEn,
    output logic [BITWIDTH-1:0]        fifoDIn,
    output logic [$clog2(NREQ)-1:0]    owner,
    output logic                       busy
);

    localparam int unsigned OW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAX_BURST) + 1;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [OW-1:0]       pick;
    logic [OW-1:0]       idx;
    logic                found;
    logic                owner_req;
    logic [BITWIDTH-1:0] owner_word;
    logic                last_word;

    // Request and data word of the current owner.
    always_comb begin
        owner_req  = 1'b0;
        owner_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_q == OW'(i)) begin
                owner_req  = req[i];
                owner_word = data[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    // Search starts at ptr and wraps; NREQ is a power of two so OW-bit addition wraps for free.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = ptr_q + OW'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        fifoWEn = (state_q == StBurst) && owner_req && !fifoFull && !rst;
        fifoDIn = fifoWEn ? owner_word : '0;
        busy    = (state_q == StBurst) && !rst;
        owner   = owner_q;
        ack     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            ack[i] = fifoWEn && (owner_q == OW'(i));
        end
    end

    assign last_word = (cnt_q == CW'(MAX_BURST - 1));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d = pick;
                    cnt_d   = '0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (fifoWEn) begin
                    cnt_d = cnt_q + CW'(1);
                    if (last_word) begin
                        state_d = StIdle;
                        ptr_d   = owner_q + OW'(1);
                    end
                end else if (!owner_req) begin
                    // Producer withdrew its word: release the grant to the next in line.
                    state_d = StIdle;
                    ptr_d   = owner_q + OW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; a negedge monitor checks every FIFO write against
// a queue of expected (requester, word) pairs filled by the stimulus.
module tb_fifo_wr_arbiter;

    localparam int BW = 5;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*BW-1:0]  data;
    logic [NR-1:0]     ack;
    logic              fifoFull;
    logic              fifoWEn;
    logic [BW-1:0]     fifoDIn;
    logic [1:0]        owner;
    logic              busy;

    logic [BW-1:0]     words [NR];

    int total = 0;
    int bad   = 0;
    int exp_id [$];
    logic [BW-1:0] exp_d [$];

    always #5 clk = ~clk;

    always_comb begin
        data = '0;
        for (int i = 0; i < NR; i++) data[i*BW +: BW] = words[i];
    end

    fifo_wr_arbiter #(
        .BITWIDTH (BW),
        .NREQ     (NR),
        .MAX_BURST(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data    (data),
        .ack     (ack),
        .fifoFull(fifoFull),
        .fifoWEn (fifoWEn),
        .fifoDIn (fifoDIn),
        .owner   (owner),
        .busy    (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            exp_id.push_back(id);
            exp_d.push_back(words[id]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        fifoFull = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every write must match the next expected entry; idle bus must be clean.
    always @(negedge clk) begin
        int id;
        logic [BW-1:0] d;
        if (fifoFull) chk("wen_while_full", int'(fifoWEn), 0);
        if (fifoWEn) begin
            if (exp_id.size() == 0) begin
                chk("unexpected_write", exp_id.size(), 1);
            end else begin
                id = exp_id.pop_front();
                d  = exp_d.pop_front();
                chk("write_ack", int'(ack), 1 << id);
                chk("write_owner", int'(owner), id);
                chk("write_data", int'(fifoDIn), int'(d));
            end
        end else begin
            chk("idle_ack", int'(ack), 0);
            chk("idle_dout", int'(fifoDIn), 0);
        end
    end

    initial begin
        rst = 1'b1;
        req = '0;
        fifoFull = 1'b0;
        for (int i = 0; i < NR; i++) words[i] = BW'(5'h10 + i);

        // Reset state
        do_reset();
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_owner", int'(owner), 0);
        chk("rst_wen", int'(fifoWEn), 0);

        // Single requester: grant, four writes, exit
        words[0] = 5'h0A;
        req = 4'b0001;
        push(0, 4);
        tick();
        chk("t1_busy_grant", int'(busy), 1);
        chk("t1_owner", int'(owner), 0);
        repeat (4) tick();
        chk("t1_busy_exit", int'(busy), 0);
        req = '0;
        tick();
        words[0] = 5'h10;

        // All four requesting: order 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 4);
        repeat (25) tick();
        req = '0;
        tick();
        chk("t2_idle", int'(busy), 0);

        // Full stall after two words of owner 2
        do_reset();
        req = 4'b0100;
        push(2, 4);
        repeat (3) tick();
        fifoFull = 1'b1;
        #1;
        chk("t3_stall_wen", int'(fifoWEn), 0);
        chk("t3_stall_ack", int'(ack), 0);
        repeat (3) begin
            tick();
            chk("t3_stall_owner", int'(owner), 2);
            chk("t3_stall_busy", int'(busy), 1);
        end
        fifoFull = 1'b0;
        repeat (2) tick();
        chk("t3_exit", int'(busy), 0);
        req = '0;
        tick();

        // Early release by owner 1 while 3 waits; 2 not requesting
        do_reset();
        req = 4'b1010;
        push(1, 1);
        push(3, 4);
        tick();
        chk("t4_owner1", int'(owner), 1);
        tick();
        req = 4'b1000;
        tick();
        chk("t4_released", int'(busy), 0);
        tick();
        chk("t4_owner3", int'(owner), 3);
        chk("t4_busy3", int'(busy), 1);
        repeat (4) tick();
        req = '0;
        tick();

        // Reset during the third word of owner 1
        do_reset();
        req = 4'b0110;
        push(1, 2);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_wen", int'(fifoWEn), 0);
        chk("t5_rst_ack", int'(ack), 0);
        chk("t5_rst_dout", int'(fifoDIn), 0);
        chk("t5_rst_busy", int'(busy), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_post_owner", int'(owner), 0);
        chk("t5_post_busy", int'(busy), 0);
        push(1, 4);
        tick();
        chk("t5_regrant", int'(owner), 1);
        chk("t5_regrant_busy", int'(busy), 1);
        repeat (4) tick();
        req = '0;
        tick();

        // Wrap-around: a burst of owner 2 leaves ptr=3, then req=0101
        do_reset();
        req = 4'b0100;
        push(2, 4);
        repeat (5) tick();
        req = 4'b0101;
        push(0, 4);
        push(2, 4);
        tick();
        chk("t6_wrap_owner0", int'(owner), 0);
        repeat (5) tick();
        chk("t6_next_owner2", int'(owner), 2);
        repeat (4) tick();
        req = '0;
        repeat (2) tick();

        chk("queue_drained", exp_id.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
